dft_stream_core: RTL
====================

DFT_STREAM_CORE -- requirements
Module: dft_stream_core

Interface
REQ-001 SHALL have parameter N, default 8, meaning the transform length in points; N is a power of 2 in the range 4..256.
REQ-002 SHALL have parameter DW, default 16, meaning the signed width of each real and imaginary input component.
REQ-003 SHALL have parameter CW, default 16, meaning the signed twiddle component width, in Q1.(CW-1) format.
REQ-004 SHALL define derived values LN = log2(N) and OW = DW+LN+1, where OW is the output component width.
REQ-005 SHALL use one clock, ap_clk; reset is ap_rst, asynchronous and active-high.
REQ-006 SHALL have these ports:
- ap_clk  in  1  clock
- ap_rst  in  1  async active-high reset
- s_tdata  in  2*DW  input sample, {im,re}
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- s_tlast  in  1  sender end-of-frame marker
- inverse  in  1  1 = conjugate twiddles (IDFT)
- coef_we  in  1  twiddle write strobe
- coef_addr  in  LN  twiddle index
- coef_data  in  2*CW  twiddle value, {im,re}
- m_tdata  out  2*OW  output bin, {im,re}
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  marks bin N-1
- busy  out  1  high in CALC or OUT
- frame_err  out  1  one-cycle tlast-mismatch pulse

Function
REQ-007 SHALL use the states LOAD, CALC and OUT.
REQ-008 In LOAD, each s_tvalid&&s_tready handshake SHALL write the sample to buffer[n] and increment n.
REQ-009 The inverse input SHALL be latched on the handshake of sample 0 and held for the whole frame.
REQ-010 s_tready SHALL be registered, high only in LOAD, and SHALL drop in the cycle after the N-th handshake.
REQ-011 frame_err SHALL pulse for one cycle when s_tlast=1 on sample n<N-1, or when s_tlast=0 on sample N-1.
REQ-012 A tlast mismatch SHALL NOT affect framing: a frame is always exactly N samples.
REQ-013 After the N-th handshake at cycle t, the block SHALL enter CALC for bin k=0 at t+1.
REQ-014 In CALC, the block SHALL perform one complex MAC per cycle, for n = 0..N-1, using twiddle index idx, where idx=0 at bin start and idx += k each cycle, mod N (natural LN-bit wrap).
REQ-015 The twiddle used SHALL be wr=W[idx].re, and wi=W[idx].im (or -W[idx].im when inverse=1).
REQ-016 The MAC arithmetic SHALL be:
- acc_re += xr*wr - xi*wi
- acc_im += xr*wi + xi*wr
- accumulator width DW+CW+LN+1, no overflow possible
- accumulators cleared at bin start.
REQ-017 Output scaling SHALL be m_tdata component = acc[CW-1 +: OW], i.e. an arithmetic shift right by CW-1 with truncation toward minus infinity.
REQ-018 After the N-th MAC, the block SHALL enter OUT with m_tvalid=1; the first bin is valid at t+N+1.
REQ-019 In OUT, m_tdata and m_tlast SHALL hold stable until m_tready=1.
REQ-020 m_tlast SHALL be 1 only for bin k=N-1.
REQ-021 On an OUT handshake at cycle h with k<N-1, the block SHALL increment k, return to CALC, and present the next bin valid at h+N+1.
REQ-022 On an OUT handshake with k=N-1, the block SHALL go to LOAD, with s_tready=1 at h+1.
REQ-023 coef_we SHALL write W[coef_addr] only in LOAD; writes in CALC or OUT are ignored.
REQ-024 A write in the same cycle as the N-th sample handshake SHALL be accepted.
REQ-025 m_tvalid SHALL never assert outside OUT, and no bin is ever emitted twice.

Reset
REQ-026 ap_rst SHALL act immediately, independent of ap_clk, and SHALL apply these reset values:
- state LOAD
- n, k, idx and accumulators cleared
- m_tvalid, m_tlast, m_tdata, busy, frame_err all 0
- s_tready 0.
REQ-027 s_tready SHALL rise at the first ap_clk edge after ap_rst deasserts.
REQ-028 The sample buffer and twiddle table SHALL NOT be cleared by reset; their contents are retained.
REQ-029 A reset asserted mid-CALC or mid-OUT SHALL abandon the frame; no partial output follows.

Verification
REQ-030 Impulse, with N=8, DW=CW=16 and the table loaded with W[i]=round(32767*exp(-j2πi/8)): x[0]=1000+0j, others 0 -> 8 bins re=999, im=0, m_tlast on bin 7 only, first m_tvalid 9 cycles after the last s handshake.
REQ-031 DC: all x=100+0j -> bin0 re=799, im=0; bins 1..7 |re|,|im| ≤ 2.
REQ-032 Inverse: x[2]=1000+0j, bin 1 -> im=-1000 with inverse=0; im=999 with inverse=1; re ∈ {-1,0} in both cases.
REQ-033 Backpressure: m_tready held low for 5 cycles on bin 3 -> m_tdata and m_tlast stable, exactly 8 bins per frame, next s_tready only after the bin-7 handshake.
REQ-034 Framing and reset: s_tlast on sample 5 -> one frame_err pulse, 8 samples still consumed; ap_rst asserted during bin 4 CALC -> outputs 0 at once, s_tready=1 one edge after release, next frame correct using the retained table.

Source files
------------

// File: rtl/dft_stream_core.sv
// Streaming N-point DFT: loads N complex samples, then computes each bin k with one complex MAC per cycle.
// Latency: first bin valid N+1 cycles after the N-th input handshake; each further bin N+1 cycles after the previous bin handshake.
// Backpressure: s_tready is low from the N-th sample until bin N-1 is taken; output bins hold stable while m_tready is low.
//
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready input samples {im,re}, s_tlast checked against frame position
//   inverse                   sampled with sample 0; 1 conjugates the twiddles (IDFT)
//   coef_we/coef_addr/coef_data twiddle table write port {im,re}, accepted only while loading
//   m_tdata/m_tvalid/m_tready output bins {im,re}, m_tlast on bin N-1
//   busy                      high while computing or presenting bins
//   frame_err                 one-cycle pulse when s_tlast disagrees with the sample position
module dft_stream_core #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int CW = 16,
  localparam int LN = $clog2(N),
  localparam int OW = DW + LN + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [2*DW-1:0]   s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              inverse,
  input  logic              coef_we,
  input  logic [LN-1:0]     coef_addr,
  input  logic [2*CW-1:0]   coef_data,
  output logic [2*OW-1:0]   m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              frame_err
);

  // Accumulator is wide enough for N full-scale products: no overflow.
  localparam int AW = DW + CW + LN + 1;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t state, state_nxt;

  logic [LN-1:0]        n;      // sample index: load position, then MAC position
  logic [LN-1:0]        k;      // current bin
  logic [LN-1:0]        idx;    // twiddle index, steps by k each MAC
  logic                 inv_q;  // inverse flag for the current frame
  logic signed [AW-1:0] acc_re, acc_im;

  // Sample buffer and twiddle table keep their contents across reset.
  logic signed [DW-1:0] buf_re [N];
  logic signed [DW-1:0] buf_im [N];
  logic signed [CW-1:0] w_re   [N];
  logic signed [CW-1:0] w_im   [N];

  logic s_hs, m_hs, n_last, k_last;

  // s_tready is only ever high in LOAD, so a handshake implies LOAD.
  assign s_hs   = s_tvalid && s_tready;
  assign m_hs   = m_tvalid && m_tready;
  assign n_last = (n == LN'(N - 1));
  assign k_last = (k == LN'(N - 1));
  assign busy   = (state != LOAD);

  // ---------------- FSM ----------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (s_hs && n_last) state_nxt = CALC;
      CALC:    if (n_last)         state_nxt = OUT;
      OUT:     if (m_hs)           state_nxt = k_last ? LOAD : CALC;
      default:                     state_nxt = LOAD;
    endcase
  end

  // ---------------- complex MAC ----------------
  logic signed [AW-1:0] xr, xi, wr, wi_raw, wi, acc_re_nxt, acc_im_nxt;

  always_comb begin
    xr     = AW'(buf_re[n]);
    xi     = AW'(buf_im[n]);
    wr     = AW'(w_re[idx]);
    wi_raw = AW'(w_im[idx]);
    // Negate after widening so a -2^(CW-1) coefficient cannot overflow.
    wi     = inv_q ? -wi_raw : wi_raw;
    acc_re_nxt = acc_re + xr * wr - xi * wi;
    acc_im_nxt = acc_im + xr * wi + xi * wr;
  end

  // ---------------- control and datapath registers ----------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s_tready  <= 1'b0;
      n         <= '0;
      k         <= '0;
      idx       <= '0;
      inv_q     <= 1'b0;
      acc_re    <= '0;
      acc_im    <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          // Ready rises on the first edge after reset and drops right after sample N-1.
          s_tready <= !(s_hs && n_last);
          k        <= '0;
          idx      <= '0;
          acc_re   <= '0;
          acc_im   <= '0;
          if (s_hs) begin
            n         <= n + LN'(1);  // wraps to 0, ready for the first MAC
            frame_err <= n_last ? !s_tlast : s_tlast;
            if (n == '0) inv_q <= inverse;
          end
        end
        CALC: begin
          acc_re <= acc_re_nxt;
          acc_im <= acc_im_nxt;
          n      <= n + LN'(1);
          idx    <= idx + k;
          // Register the bin straight from the final MAC sum.
          if (n_last) begin
            m_tvalid <= 1'b1;
            m_tlast  <= k_last;
            m_tdata  <= {acc_im_nxt[CW-1 +: OW], acc_re_nxt[CW-1 +: OW]};
          end
        end
        OUT: begin
          if (m_hs) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            k        <= k + LN'(1);
            idx      <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            if (k_last) s_tready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- storage (no reset) ----------------
  always_ff @(posedge ap_clk) begin
    if (s_hs) begin
      buf_re[n] <= s_tdata[DW-1:0];
      buf_im[n] <= s_tdata[2*DW-1:DW];
    end
    // Table writes only while loading, including the cycle of the last sample.
    if (coef_we && state == LOAD) begin
      w_re[coef_addr] <= coef_data[CW-1:0];
      w_im[coef_addr] <= coef_data[2*CW-1:CW];
    end
  end

endmodule
